vga_sync_rx: RTL

VGA_SYNC_RX -- requirements
Module: vga_sync_rx

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_edge_det.sv | 31 +++
 rtl/vga_sync_rx.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg -- shared definitions for the VGA sync receiver.
//   rx_state_t        : lock FSM states (SEARCH, MEASURE, LOCKED)
//   VGA_*             : default 640x480@60 timing constants
//   HCNT_MAX/VCNT_MAX : saturation values of the line/frame counters
//   in_window()       : half-open range test used for the active-area decode
package vga_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } rx_state_t;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_H_TO_ACT = 144;
    localparam int VGA_V_TO_ACT = 35;

    localparam logic [10:0] HCNT_MAX = 11'd2047;
    localparam logic [9:0]  VCNT_MAX = 10'd1023;

    // True when lo <= cnt < lo + len.
    function automatic logic in_window(input int unsigned cnt,
                                       input int unsigned lo,
                                       input int unsigned len);
        return (cnt >= lo) && (cnt < lo + len);
    endfunction

endpackage

// File: rtl/vga_edge_det.sv
// vga_edge_det -- per-pixel-tick sampler for one sync line.
//   clk, rst    : system clock, asynchronous active-high reset
//   pix_en      : pixel-tick enable; the line is only looked at on these cycles
//   sync_in     : raw sync level
//   assert_tick : combinational, high on a tick whose sample is POL while the
//                 previous tick's sample was not (the assertion edge)
// The previous-sample register clears to 0, so with active-low sync a line
// that is already asserted coming out of reset is not mistaken for an edge.
module vga_edge_det #(
    parameter bit POL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pix_en,
    input  logic sync_in,
    output logic assert_tick
);

    logic prev_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_reg <= 1'b0;
        end else if (pix_en) begin
            prev_reg <= sync_in;
        end
    end

    assign assert_tick = pix_en && (sync_in == POL) && (prev_reg != POL);

endmodule

// File: rtl/vga_sync_rx.sv
// vga_sync_rx -- VGA timing receiver: measures line/frame length from
// hsync/vsync, locks once the timing is stable and emits active pixels with
// their coordinates.
//   clk, RST                 : system clock, asynchronous active-high reset
//   pix_en                   : pixel-tick enable (inputs sampled only then)
//   hsync, vsync             : sync inputs, asserted level = SYNC_POL
//   pix_r, pix_g, pix_b      : 4-bit colour components
//   px_valid/px_rgb/x/y      : registered active pixel, one clk after its tick
//   locked                   : high only in the LOCKED state
//   err                      : one-clk pulse on timing change or counter overflow
//   line_len, frame_lines    : last measured ticks/line and lines/frame
//   frame_sum(_valid)        : per-frame 16-bit pixel checksum, only when the
//                              VGA_RX_CHECKSUM_EN macro is defined; tied to 0
//                              otherwise
module vga_sync_rx
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int H_TO_ACT    = VGA_H_TO_ACT,
    parameter int V_TO_ACT    = VGA_V_TO_ACT,
    parameter int LOCK_FRAMES = 2,
    parameter int SYNC_POL    = 0
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        pix_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  pix_r,
    input  logic [3:0]  pix_g,
    input  logic [3:0]  pix_b,
    output logic        px_valid,
    output logic [11:0] px_rgb,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        locked,
    output logic        err,
    output logic [10:0] line_len,
    output logic [9:0]  frame_lines,
    output logic [15:0] frame_sum,
    output logic        frame_sum_valid
);

    logic        hs_tick, vs_tick;
    logic [11:0] pix_in;
    logic [10:0] hcnt_reg, hcnt_next, ll_new;
    logic [9:0]  vcnt_reg, vcnt_next, fl_new;
    rx_state_t   state_reg;
    logic [7:0]  match_reg, run_next;
    logic        ref_valid_reg, line_chg_reg;
    logic        line_chg_now, frame_chg_now, line_chg_frame, frame_clean;
    logic        sat_hit, active;

    vga_edge_det #(.POL(SYNC_POL != 0)) u_hs_det (
        .clk         (clk),
        .rst         (RST),
        .pix_en      (pix_en),
        .sync_in     (hsync),
        .assert_tick (hs_tick)
    );

    vga_edge_det #(.POL(SYNC_POL != 0)) u_vs_det (
        .clk         (clk),
        .rst         (RST),
        .pix_en      (pix_en),
        .sync_in     (vsync),
        .assert_tick (vs_tick)
    );

    assign pix_in = {pix_r, pix_g, pix_b};

    // Counter values as they will be after this tick; a coincident vsync
    // assertion wins over the hsync increment of vcnt.
    always_comb begin
        hcnt_next = hcnt_reg;
        vcnt_next = vcnt_reg;
        if (pix_en) begin
            if (hs_tick) begin
                hcnt_next = '0;
            end else if (hcnt_reg != HCNT_MAX) begin
                hcnt_next = hcnt_reg + 11'd1;
            end
            if (vs_tick) begin
                vcnt_next = '0;
            end else if (hs_tick && (vcnt_reg != VCNT_MAX)) begin
                vcnt_next = vcnt_reg + 10'd1;
            end
        end
    end

    // Measurements that would be latched this tick (saturating).
    assign ll_new = (hcnt_reg == HCNT_MAX) ? HCNT_MAX : hcnt_reg + 11'd1;
    assign fl_new = (vcnt_reg == VCNT_MAX) ? VCNT_MAX : vcnt_reg + 10'd1;

    assign line_chg_now   = hs_tick && (ll_new != line_len);
    assign frame_chg_now  = vs_tick && (fl_new != frame_lines);
    // A line change on the tick that closes the frame still belongs to it.
    assign line_chg_frame = line_chg_reg || line_chg_now;

    // Overflow fires once, on the tick a counter first reaches its ceiling.
    assign sat_hit = pix_en &&
                     (((hcnt_next == HCNT_MAX) && (hcnt_reg != HCNT_MAX)) ||
                      ((vcnt_next == VCNT_MAX) && (vcnt_reg != VCNT_MAX)));

    assign active = pix_en && (state_reg == LOCKED) &&
                    in_window(32'(hcnt_next), H_TO_ACT, H_ACTIVE) &&
                    in_window(32'(vcnt_next), V_TO_ACT, V_ACTIVE);

    // Run length of consecutive identical frames after the frame now closing.
    // Without a valid reference, a frame with steady lines starts a new run.
    always_comb begin
        frame_clean = ref_valid_reg && !line_chg_frame && !frame_chg_now;
        if (frame_clean) begin
            run_next = (match_reg == 8'hFF) ? match_reg : match_reg + 8'd1;
        end else begin
            run_next = line_chg_frame ? 8'd0 : 8'd1;
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_reg     <= SEARCH;
            hcnt_reg      <= '0;
            vcnt_reg      <= '0;
            match_reg     <= '0;
            ref_valid_reg <= 1'b0;
            line_chg_reg  <= 1'b0;
            line_len      <= '0;
            frame_lines   <= '0;
            locked        <= 1'b0;
            err           <= 1'b0;
            px_valid      <= 1'b0;
            px_rgb        <= '0;
            x             <= '0;
            y             <= '0;
        end else begin
            err      <= 1'b0;
            px_valid <= 1'b0;
            if (pix_en) begin
                hcnt_reg <= hcnt_next;
                vcnt_reg <= vcnt_next;
                if (hs_tick) begin
                    line_len <= ll_new;
                    if (line_chg_now) begin
                        line_chg_reg <= 1'b1;
                    end
                end
                if (vs_tick) begin
                    frame_lines  <= fl_new;
                    line_chg_reg <= 1'b0;
                end
                if (active) begin
                    px_valid <= 1'b1;
                    px_rgb   <= pix_in;
                    x        <= 10'(hcnt_next - 11'(H_TO_ACT));
                    y        <= vcnt_next - 10'(V_TO_ACT);
                end

                if (sat_hit) begin
                    err           <= 1'b1;
                    locked        <= 1'b0;
                    state_reg     <= SEARCH;
                    match_reg     <= '0;
                    ref_valid_reg <= 1'b0;
                end else begin
                    case (state_reg)
                        SEARCH: begin
                            if (vs_tick) begin
                                state_reg     <= MEASURE;
                                match_reg     <= '0;
                                ref_valid_reg <= 1'b0;
                            end
                        end
                        MEASURE: begin
                            if (vs_tick) begin
                                match_reg     <= run_next;
                                ref_valid_reg <= !line_chg_frame;
                                if (int'(run_next) >= LOCK_FRAMES) begin
                                    state_reg <= LOCKED;
                                    locked    <= 1'b1;
                                end
                            end
                        end
                        LOCKED: begin
                            if (line_chg_now || frame_chg_now) begin
                                err           <= 1'b1;
                                locked        <= 1'b0;
                                state_reg     <= MEASURE;
                                match_reg     <= '0;
                                ref_valid_reg <= 1'b0;
                            end
                        end
                        default: begin
                            locked    <= 1'b0;
                            state_reg <= SEARCH;
                        end
                    endcase
                end
            end
        end
    end

`ifdef VGA_RX_CHECKSUM_EN
    logic [15:0] acc_reg;

    // The sum covers the frame that the vsync assertion closes; it is only
    // published if that frame was received while locked.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            acc_reg         <= '0;
            frame_sum       <= '0;
            frame_sum_valid <= 1'b0;
        end else begin
            frame_sum_valid <= 1'b0;
            if (pix_en) begin
                if (vs_tick) begin
                    if (state_reg == LOCKED) begin
                        frame_sum       <= acc_reg;
                        frame_sum_valid <= 1'b1;
                    end
                    acc_reg <= '0;
                end else if (active) begin
                    acc_reg <= acc_reg + 16'(pix_in);
                end
            end
        end
    end
`else
    assign frame_sum       = '0;
    assign frame_sum_valid = 1'b0;
`endif

endmodule
